// File: rtl/wb_port_arbiter_if.sv
// Writeback arbitration bus: pipeline W-stage port, multi-cycle unit port,
// register-file write port and hazard query, grouped for wb_port_arbiter.
interface wb_port_arbiter_if;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;

  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;

  logic        rf_write_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  logic        stall_req;
  logic [4:0]  query_rd;
  logic        query_hit;

  modport slave (
    input  reg_write_w, rd_w, result_w,
    input  mc_valid, mc_rd, mc_data,
    input  query_rd,
    output mc_ready, rf_write_en, rf_addr, rf_data, stall_req, query_hit
  );

  modport master (
    output reg_write_w, rd_w, result_w,
    output mc_valid, mc_rd, mc_data,
    output query_rd,
    input  mc_ready, rf_write_en, rf_addr, rf_data, stall_req, query_hit
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline W stage and a
// queued multi-cycle unit. Define WB_ARB_STARVE_EN to add forced FIFO drains.
module wb_port_arbiter (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
`else
  typedef enum logic {IDLE, PEND} state_t;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, wr_ptr_reg;
  logic [4:0]  rd_mem [2];
  logic [31:0] data_mem [2];

  logic        pipe_valid, mc_keep, grant_head, grant_bypass, enq, stall_int;
  logic        we_int;
  logic [4:0]  addr_int;
  logic [31:0] data_int;
  logic [1:0]  hit;

`ifdef WB_ARB_STARVE_EN
  logic [1:0]  wait_cnt_reg, wait_cnt_next;
  assign stall_int = (state_reg == FORCE);
`else
  assign stall_int = 1'b0;
`endif

  assign pipe_valid    = bus.reg_write_w && (bus.rd_w != 5'd0);
  // No dequeue lookahead: a full FIFO refuses even when the head leaves now.
  assign bus.mc_ready  = !rst && (count_reg != 2'd2);
  assign mc_keep       = bus.mc_valid && bus.mc_ready && (bus.mc_rd != 5'd0);
  assign enq           = mc_keep && !grant_bypass;
  assign count_next    = count_reg + {1'b0, enq} - {1'b0, grant_head};
  assign bus.stall_req = stall_int;

  always_comb begin
    grant_head   = 1'b0;
    grant_bypass = 1'b0;
    we_int       = 1'b0;
    addr_int     = 5'd0;
    data_int     = 32'd0;
    if (!rst) begin
      if (stall_int) begin
        grant_head = 1'b1;
      end else if (pipe_valid) begin
        we_int   = 1'b1;
        addr_int = bus.rd_w;
        data_int = bus.result_w;
      end else if (count_reg != 2'd0) begin
        grant_head = 1'b1;
      end else if (mc_keep) begin
        grant_bypass = 1'b1;
        we_int       = 1'b1;
        addr_int     = bus.mc_rd;
        data_int     = bus.mc_data;
      end
      if (grant_head) begin
        we_int   = 1'b1;
        addr_int = rd_mem[rd_ptr_reg];
        data_int = data_mem[rd_ptr_reg];
      end
    end
  end

  assign bus.rf_write_en = we_int;
  assign bus.rf_addr     = addr_int;
  assign bus.rf_data     = data_int;

  always_comb begin
    state_next = state_reg;
`ifdef WB_ARB_STARVE_EN
    wait_cnt_next = 2'd0;
`endif
    case (state_reg)
      IDLE: if (enq) state_next = PEND;
      PEND: begin
        if (count_next == 2'd0) begin
          state_next = IDLE;
`ifdef WB_ARB_STARVE_EN
        end else if (!grant_head) begin
          if (wait_cnt_reg == 2'd3) state_next = FORCE;
          else wait_cnt_next = wait_cnt_reg + 2'd1;
`endif
        end
      end
`ifdef WB_ARB_STARVE_EN
      FORCE: state_next = (count_next == 2'd0) ? IDLE : PEND;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
`ifdef WB_ARB_STARVE_EN
      wait_cnt_reg <= 2'd0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (enq)        wr_ptr_reg <= ~wr_ptr_reg;
      if (grant_head) rd_ptr_reg <= ~rd_ptr_reg;
`ifdef WB_ARB_STARVE_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  // Per-entry storage and hazard compare; an entry is live only while counted.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (enq && (wr_ptr_reg == 1'(gi))) begin
          rd_mem[gi]   <= bus.mc_rd;
          data_mem[gi] <= bus.mc_data;
        end
      end
      assign hit[gi] = ((count_reg == 2'd2) ||
                        ((count_reg == 2'd1) && (rd_ptr_reg == 1'(gi)))) &&
                       (rd_mem[gi] == bus.query_rd);
    end
  endgenerate

  assign bus.query_hit = (|hit) && (bus.query_rd != 5'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();
  wb_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } entry_t;

  entry_t q[$];
  int     waited   = 0;
  bit     force_m  = 1'b0;
  int     pass_cnt = 0;
  int     fail_cnt = 0;
  int     total_cnt = 0;
  int     cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, then advance the model.
  task automatic step(input bit r, input bit rwe, input logic [4:0] rdw,
                      input logic [31:0] resw, input bit mcv, input logic [4:0] mcrd,
                      input logic [31:0] mcd, input logic [4:0] qrd);
    bit exp_ready, exp_we, hd, byp, hit;
    logic [4:0]  ea;
    logic [31:0] ed;
    entry_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.reg_write_w = rwe;
    bus.rd_w        = rdw;
    bus.result_w    = resw;
    bus.mc_valid    = mcv;
    bus.mc_rd       = mcrd;
    bus.mc_data     = mcd;
    bus.query_rd    = qrd;
    @(negedge clk);
    cyc++;
    exp_ready = !r && (q.size() < 2);
    exp_we = 1'b0; ea = 5'd0; ed = 32'd0; hd = 1'b0; byp = 1'b0;
    if (!r) begin
      if (force_m) hd = 1'b1;
      else if (rwe && rdw != 5'd0) begin exp_we = 1'b1; ea = rdw; ed = resw; end
      else if (q.size() > 0) hd = 1'b1;
      else if (mcv && exp_ready && mcrd != 5'd0) begin
        byp = 1'b1; exp_we = 1'b1; ea = mcrd; ed = mcd;
      end
      if (hd) begin exp_we = 1'b1; ea = q[0].rd; ed = q[0].d; end
    end
    hit = 1'b0;
    if (qrd != 5'd0) foreach (q[i]) if (q[i].rd == qrd) hit = 1'b1;

    chk("rf_write_en", {31'd0, bus.rf_write_en}, {31'd0, exp_we});
    chk("rf_addr", {27'd0, bus.rf_addr}, {27'd0, ea});
    chk("rf_data", bus.rf_data, ed);
    chk("mc_ready", {31'd0, bus.mc_ready}, {31'd0, exp_ready});
    chk("stall_req", {31'd0, bus.stall_req}, {31'd0, force_m});
    chk("query_hit", {31'd0, bus.query_hit}, {31'd0, hit});
    $display("cyc %0d rst=%0b pipe=%0b/x%0d mc=%0b/x%0d we=%0b x%0d=%h stall=%0b ready=%0b qsz=%0d",
             cyc, r, rwe, rdw, mcv, mcrd, bus.rf_write_en, bus.rf_addr, bus.rf_data,
             bus.stall_req, bus.mc_ready, q.size());

    if (r) begin
      q.delete();
      waited  = 0;
      force_m = 1'b0;
    end else begin
`ifdef WB_ARB_STARVE_EN
      bit ne;
      ne = (q.size() > 0);
`endif
      if (hd) void'(q.pop_front());
      if (mcv && exp_ready && mcrd != 5'd0 && !byp) begin
        e.rd = mcrd; e.d = mcd;
        q.push_back(e);
      end
`ifdef WB_ARB_STARVE_EN
      if (force_m) begin
        force_m = 1'b0; waited = 0;
      end else if (ne && !hd) begin
        waited++;
        if (waited == 4) begin force_m = 1'b1; waited = 0; end
      end else begin
        waited = 0;
      end
`endif
    end
  endtask

  task automatic idle(input logic [4:0] qrd);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qrd);
  endtask

  initial begin
    rst = 1'b1;
    bus.reg_write_w = 1'b0; bus.rd_w = 5'd0; bus.result_w = 32'd0;
    bus.mc_valid = 1'b0; bus.mc_rd = 5'd0; bus.mc_data = 32'd0; bus.query_rd = 5'd0;
    repeat (2) @(posedge clk);

    // Reset state
    idle(5'd0);
    chk("reset_ready", {31'd0, bus.mc_ready}, 32'd1);
    chk("reset_stall", {31'd0, bus.stall_req}, 32'd0);

    // Bypass with empty FIFO and idle pipe
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5);
    chk("bypass_we", {31'd0, bus.rf_write_en}, 32'd1);
    chk("bypass_addr", {27'd0, bus.rf_addr}, 32'd5);
    chk("bypass_data", bus.rf_data, 32'hDEADBEEF);
    idle(5'd5);
    chk("bypass_not_queued", {31'd0, bus.query_hit}, 32'd0);

    // Pipe wins, MC result queued then drained in the next free slot
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7);
    chk("prio_addr", {27'd0, bus.rf_addr}, 32'd3);
    chk("prio_data", bus.rf_data, 32'h11);
    idle(5'd7);
    chk("drain_addr", {27'd0, bus.rf_addr}, 32'd7);
    chk("drain_data", bus.rf_data, 32'h22);

    // x0 handling
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0);
    chk("x0_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
    chk("x0_mc_no_write", {31'd0, bus.rf_write_en}, 32'd0);
    step(1'b0, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("x0_pipe_no_write", {31'd0, bus.rf_write_en}, 32'd0);
    step(1'b0, 1'b1, 5'd0, 32'h66, 1'b1, 5'd4, 32'h44, 5'd0);
    chk("x0_pipe_free_slot", {27'd0, bus.rf_addr}, 32'd4);

    // Full FIFO under continuous pipe writes
    step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h88, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h99, 5'd0);
    step(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd10, 32'hAA, 5'd9);
    chk("full_ready", {31'd0, bus.mc_ready}, 32'd0);
    chk("full_hit", {31'd0, bus.query_hit}, 32'd1);

    // Keep pipe busy until a forced drain is pending, then reset over it
    for (int i = 0; i < 10 && !force_m; i++)
      step(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd10, 32'hAA, 5'd10);
    step(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd11, 32'hBB, 5'd9);
    idle(5'd9);
    chk("post_rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.mc_ready}, 32'd1);
    chk("post_rst_no_write", {31'd0, bus.rf_write_en}, 32'd0);
    chk("post_rst_no_hit", {31'd0, bus.query_hit}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
REQ-002 Pipeline writeback port SHALL be:
- Reg_Write_W  in  1  write enable
- Rd_W  in  5  destination register
- Result_W  in  32  writeback mux output
REQ-003 Multi-cycle unit port SHALL be:
- MC_Valid  in  1  result valid
- MC_Rd  in  5  destination register
- MC_Data  in  32  result data
- MC_Ready  out  1  result accepted this cycle when high
REQ-004 Register-file write port SHALL be:
- RF_Write_En  out  1  write enable
- RF_Addr  out  5  write address
- RF_Data  out  32  write data
REQ-005 Control and hazard ports SHALL be:
- Stall_Req  out  1  registered; pipeline holds the W stage while high
- Query_Rd  in  5  register address to check
- Query_Hit  out  1  combinational; high if any valid FIFO entry has rd == Query_Rd, and low when Query_Rd = 0

Function
REQ-006 A pipe write is valid when Reg_Write_W=1 and Rd_W!=0; otherwise the cycle is a free slot.
REQ-007 MC results SHALL queue in a 2-entry in-order FIFO (rd + data); MC_Ready = (count<2), computed from registered count only, with no dequeue lookahead.
REQ-008 An MC handshake with MC_Rd=0 SHALL be accepted and dropped, never enqueued or written.
REQ-009 Grant priority, evaluated combinationally each cycle:
- (a) Stall_Req=1: grant FIFO head; ignore the pipe.
- (b) else valid pipe write: grant pipe.
- (c) else FIFO non-empty: grant head.
- (d) else MC_Valid && MC_Ready && MC_Rd!=0: bypass MC directly to the RF port (zero latency, not enqueued).
- (e) else RF_Write_En=0.
REQ-010 The granted source SHALL drive RF_Addr/RF_Data. When RF_Write_En=0, RF_Addr and RF_Data SHALL be 0.
REQ-011 Same-cycle head dequeue and MC enqueue SHALL both take effect, leaving count unchanged.
REQ-012 FSM states:
- IDLE: FIFO empty.
- PEND: FIFO non-empty, Stall_Req=0.
- FORCE: Stall_Req=1.
REQ-013 FSM transitions:
- IDLE -> PEND on an enqueue.
- PEND -> IDLE when the FIFO becomes empty.
- PEND -> FORCE when Wait_Cnt=3 and the head is not granted.
- FORCE -> PEND/IDLE after exactly one cycle, per the post-dequeue count.
REQ-014 Wait_Cnt (2-bit) behaviour:
- Increments each PEND cycle in which the head is not granted.
- Clears on a head grant, on entering IDLE, and in FORCE.
- Saturation cannot occur.
REQ-015 Stall_Req SHALL be high only in FORCE, for exactly one cycle per forced drain.
REQ-016 WAW ordering between FIFO entries and pipe writes is the responsibility of decode, which SHALL stall on Query_Hit. The block itself performs no rd comparison on writes.

Reset
REQ-017 RST SHALL take effect at the next CLK edge, overriding all other activity:
- FIFO count=0, Wait_Cnt=0, FSM=IDLE, Stall_Req=0.
- In-flight FIFO entries are discarded.
REQ-018 In the cycle RST is high, RF_Write_En and MC_Ready SHALL be 0. Combinational outputs SHALL reflect the reset state from the first post-reset cycle.

Configuration
REQ-019 Macro WB_ARB_STARVE_EN: when defined, Wait_Cnt, the FORCE state and Stall_Req SHALL be implemented as in REQ-012 to REQ-015.
REQ-020 Without WB_ARB_STARVE_EN:
- Stall_Req is tied to 0 and there is no FORCE state.
- The FIFO drains only in free slots.
- All other behaviour is unchanged.

Verification
REQ-021 Bypass: FIFO empty, pipe idle, MC_Valid=1, MC_Rd=5, MC_Data=0xDEADBEEF -> same cycle RF_Write_En=1, RF_Addr=5, RF_Data=0xDEADBEEF; count stays 0.
REQ-022 Priority: pipe writes rd=3 value 0x11 while MC delivers rd=7 value 0x22 -> RF writes x3=0x11 that cycle; x7 enqueued. Next free slot -> x7=0x22.
REQ-023 Full FIFO: pipe writes every cycle; MC offers rd 8, 9, 10 -> 8 and 9 are accepted; MC_Ready=0 while count=2; Query_Rd=9 -> Query_Hit=1.
REQ-024 Starvation (WB_ARB_STARVE_EN defined): one entry queued and continuous pipe writes -> Stall_Req=1 on the 5th cycle; RF writes the head, pipe ignored; Stall_Req=0 the following cycle. Without the macro -> Stall_Req stays 0 indefinitely.
REQ-025 Reset mid-operation: count=2, FSM in FORCE, RST=1 for one cycle -> next cycle count=0, Stall_Req=0, MC_Ready=1, and no write of the discarded entries.
REQ-026 x0 handling: MC_Rd=0 with MC_Valid=1 -> MC_Ready=1, no RF write, count unchanged. Pipe Rd_W=0 with Reg_Write_W=1 -> treated as a free slot.
